if_inst_buffer: RTL and testbench

//  Fetch-side instruction queue: producer end of the decoder's inst/pc interface.

---
 rtl/if_inst_buffer_pkg.sv | 13 +
 rtl/if_ibuf_mem.sv | 36 +++
 rtl/if_inst_buffer.sv | 101 ++++++++++
 tb/tb_if_inst_buffer.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/if_inst_buffer_pkg.sv
// Shared constants and helpers for the fetch-side instruction buffer.
// The fetch width, exception code width and NOP encoding live here.
package if_inst_buffer_pkg;

    localparam int          IBUF_FETCH_W = 2;
    localparam int          IBUF_ECODE_W = 7;
    localparam logic [31:0] INST_NOP     = 32'h0340_0000;  // andi r0,r0,0

    function automatic logic [1:0] popcnt2(input logic [IBUF_FETCH_W-1:0] m);
        return (m == 2'b11) ? 2'd2 : {1'b0, |m};
    endfunction

endpackage

// File: rtl/if_ibuf_mem.sv
// Instruction buffer storage: two write ports at consecutive wrap-aware
// addresses and one asynchronous read port at the head.
module if_ibuf_mem #(
    parameter int DEPTH = 8,
    parameter int W     = 71
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we0,
    input  logic                     i_we1,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata0,
    input  logic [W-1:0]             i_wdata1,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] w_waddr1;

    // Second slot lands at the next address; AW-bit add wraps naturally.
    assign w_waddr1 = i_waddr + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (i_we0) r_mem[i_waddr]  <= i_wdata0;
            if (i_we1) r_mem[w_waddr1] <= i_wdata1;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_inst_buffer.sv
// Fetch-side instruction queue: accepts up to two instructions per cycle,
// compacts partial packets and issues one {pc, inst, excp} per cycle.
module if_inst_buffer
    import if_inst_buffer_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int ECODE_W = IBUF_ECODE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_pc,
    input  logic [31:0]             in_inst0,
    input  logic [31:0]             in_inst1,
    input  logic [IBUF_FETCH_W-1:0] in_mask,
    input  logic [ECODE_W-1:0]      in_excp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_pc,
    output logic [31:0]             out_inst,
    output logic [ECODE_W-1:0]      out_excp
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 64 + ECODE_W;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_head, r_tail;
    logic [CNT_W-1:0] r_count;
    logic [ENT_W-1:0] r_last;

    logic             w_push, w_pop, w_excp, w_we0, w_we1;
    logic [31:0]      w_pc1, w_inst0, w_inst1;
    logic [ENT_W-1:0] w_ent0, w_ent1, w_head_ent, w_out_ent;
    logic [CNT_W-1:0] w_push_n, w_pop_n;

    assign in_ready  = (DEPTH_C - r_count) >= CNT_W'(2);
    assign out_valid = (r_count != '0);

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    // Faulting fetches carry a NOP so the decoder sees no bogus opcode.
    assign w_excp  = (in_excp != '0);
    assign w_inst0 = w_excp ? INST_NOP : in_inst0;
    assign w_inst1 = w_excp ? INST_NOP : in_inst1;
    assign w_pc1   = in_pc + 32'd4;

    // Compaction: the first valid slot always goes to the tail entry.
    assign w_ent0 = in_mask[0] ? {in_pc, w_inst0, in_excp} : {w_pc1, w_inst1, in_excp};
    assign w_ent1 = {w_pc1, w_inst1, in_excp};
    assign w_we0  = w_push & (|in_mask);
    assign w_we1  = w_push & (&in_mask);

    assign w_push_n = w_push ? CNT_W'(popcnt2(in_mask)) : '0;
    assign w_pop_n  = CNT_W'(w_pop);

    if_ibuf_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .i_we0    (w_we0),
        .i_we1    (w_we1),
        .i_waddr  (r_tail),
        .i_wdata0 (w_ent0),
        .i_wdata1 (w_ent1),
        .i_raddr  (r_head),
        .o_rdata  (w_head_ent)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_n);
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    // While empty the outputs keep showing the last head entry presented.
    always_ff @(posedge clk) begin
        if (rst)            r_last <= '0;
        else if (out_valid) r_last <= w_head_ent;
    end

    assign w_out_ent = out_valid ? w_head_ent : r_last;
    assign out_pc    = w_out_ent[ENT_W-1 -: 32];
    assign out_inst  = w_out_ent[ECODE_W +: 32];
    assign out_excp  = w_out_ent[ECODE_W-1:0];

endmodule

// File: tb/tb_if_inst_buffer.sv
// Directed bench for if_inst_buffer (DEPTH=8): reset, compaction, full,
// wrap under steady push/pop, flush, mid-run reset and exception entries.
module tb_if_inst_buffer;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_inst0, in_inst1, out_pc, out_inst;
    logic [1:0]  in_mask;
    logic [6:0]  in_excp, out_excp;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q[$];
    logic [31:0] pc_next;
    logic        exp_rdy, m_push, m_pop;

    always #5 clk = ~clk;

    if_inst_buffer #(.DEPTH(8), .ECODE_W(7)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_inst0(in_inst0), .in_inst1(in_inst1), .in_mask(in_mask), .in_excp(in_excp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_excp(out_excp)
    );

    always @(posedge clk)
        if (!rst) assert (dut.r_count <= 5'd8) else $error("count exceeds depth");

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] m, input logic [6:0] e);
        in_valid = 1'b1; in_pc = pc; in_inst0 = i0; in_inst1 = i1; in_mask = m; in_excp = e;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_inst0 = '0; in_inst1 = '0; in_mask = '0; in_excp = '0;
        step(); step();
        rst = 1'b0;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_opc",    out_pc,    0);
        chk("rst_oinst",  out_inst,  0);
        chk("rst_oexcp",  out_excp,  0);
        chk("rst_irdy",   in_ready,  1);

        // 1: full packet, two pops, empty holds last head
        push(32'h1c00_0000, 32'h0280_0421, 32'h0280_0842, 2'b11, 7'h0);
        chk("t1_valid", out_valid, 1);
        chk("t1_pc0",   out_pc,    32'h1c00_0000);
        chk("t1_inst0", out_inst,  32'h0280_0421);
        pop();
        chk("t1_pc1",   out_pc,    32'h1c00_0004);
        chk("t1_inst1", out_inst,  32'h0280_0842);
        pop();
        chk("t1_empty", out_valid, 0);
        chk("t1_hold",  out_pc,    32'h1c00_0004);

        // 2: slot1-only packet compacts to a single entry
        push(32'h1c00_0010, 32'hdead_beef, 32'h1111_1111, 2'b10, 7'h0);
        chk("t2_pc",   out_pc,   32'h1c00_0014);
        chk("t2_inst", out_inst, 32'h1111_1111);
        pop();
        chk("t2_empty", out_valid, 0);

        // 3: fill to DEPTH with consumer stalled, then drain in order
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t3_rdy%0d", k), in_ready, 1);
            push(32'h1c00_0100 + 32'(8*k), 32'(k), 32'(k+100), 2'b11, 7'h0);
        end
        chk("t3_full_rdy", in_ready, 0);
        in_valid = 1'b1; in_pc = 32'h1c00_0200; in_mask = 2'b11;
        step(); step();
        in_valid = 1'b0;
        chk("t3_held_rdy", in_ready, 0);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t3_pc%0d", j), out_pc, 32'h1c00_0100 + 32'(4*j));
            pop();
            if (j == 0) chk("t3_rdy_cnt7", in_ready, 0);
            if (j == 1) chk("t3_rdy_cnt6", in_ready, 1);
        end
        chk("t3_empty", out_valid, 0);

        // 4: steady push 2 / pop 1 across the pointer wrap, scoreboard model
        pc_next = 32'h1c00_1000;
        q.delete();
        for (int c = 0; c < 14; c++) begin
            in_valid = 1'b1; in_mask = 2'b11; in_pc = pc_next; in_excp = '0; out_ready = 1'b1;
            exp_rdy = (8 - q.size()) >= 2;
            chk($sformatf("t4_rdy%0d", c), in_ready, exp_rdy);
            chk($sformatf("t4_vld%0d", c), out_valid, q.size() != 0);
            if (q.size() != 0) chk($sformatf("t4_pc%0d", c), out_pc, q[0]);
            m_pop = q.size() != 0;
            m_push = exp_rdy;
            if (m_push) begin
                q.push_back(pc_next); q.push_back(pc_next + 32'd4);
                pc_next += 32'd8;
            end
            if (m_pop) void'(q.pop_front());
            step();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            chk($sformatf("t4_drain%0d", c), out_pc, q[0]);
            void'(q.pop_front());
            step();
        end
        out_ready = 1'b0;
        chk("t4_empty", out_valid, 0);

        // 5: flush with 5 entries and a packet offered in the same cycle
        push(32'h1c00_0300, 32'h1, 32'h2, 2'b11, 7'h0);
        push(32'h1c00_0308, 32'h3, 32'h4, 2'b11, 7'h0);
        push(32'h1c00_0310, 32'h5, 32'h6, 2'b01, 7'h0);
        chk("t5_pre_rdy", in_ready, 1);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h1c00_dea0; in_mask = 2'b11;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_ovalid", out_valid, 0);
        chk("t5_irdy",   in_ready,  1);
        push(32'h1c00_0800, 32'h7, 32'h8, 2'b01, 7'h0);
        chk("t5_next_pc", out_pc, 32'h1c00_0800);
        pop();
        chk("t5_empty", out_valid, 0);

        // mid-run reset beats flush and push
        push(32'h1c00_0900, 32'h9, 32'ha, 2'b11, 7'h0);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rst2_ovalid", out_valid, 0);
        chk("rst2_opc",    out_pc,    0);
        chk("rst2_irdy",   in_ready,  1);

        // 6: exception packet stores NOPs and carries the code
        push(32'h1c00_0a00, 32'h0280_0421, 32'h0280_0842, 2'b11, 7'h08);
        chk("t6_inst0", out_inst, 32'h0340_0000);
        chk("t6_excp0", out_excp, 7'h08);
        chk("t6_pc0",   out_pc,   32'h1c00_0a00);
        pop();
        chk("t6_inst1", out_inst, 32'h0340_0000);
        chk("t6_excp1", out_excp, 7'h08);
        chk("t6_pc1",   out_pc,   32'h1c00_0a04);
        pop();
        chk("t6_empty", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
